// File: rtl/reg_load_arbiter.sv
// Round-robin write arbiter that owns a shared W-bit register, with a post-write hold window.
// Optional macro ARB_FIXED_PRIO_EN: fixed priority (lowest index wins), ptr frozen at 0.
module reg_load_arbiter #(
  parameter  int NREQ     = 4,
  parameter  int W        = 8,
  parameter  int HOLD_CYC = 2,
  localparam int IDW      = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] din,
  output logic [NREQ-1:0]   gnt,
  output logic              load_o,
  output logic [W-1:0]      q,
  output logic              busy,
  output logic [IDW-1:0]    last_id
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t         state;
  logic [IDW-1:0] ptr;
  logic [3:0]     hold_cnt;

  logic [IDW-1:0] winner;
  logic           any_req;
  logic [IDW-1:0] idx;
  int             sum;
  logic [W-1:0]   sel_data;

  // Scan starting at ptr; with ptr frozen at 0 the same scan is fixed priority.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    sum     = 0;
    idx     = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum = int'(ptr) + i;
      if (sum >= NREQ) sum = sum - NREQ;
      idx = IDW'(sum);
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        winner  = idx;
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (last_id == IDW'(i)) sel_data = din[i*W +: W];
    end
  end

  assign load_o = (state == GRANT);
  assign busy   = (state != IDLE);

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create ordering-dependent logic.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      q        <= '0;
      last_id  <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt     <= {{(NREQ-1){1'b0}}, 1'b1} << winner;
            last_id <= winner;
            state   <= GRANT;
          end else begin
            gnt <= '0;
          end
        end
        GRANT: begin
          q   <= sel_data;
          gnt <= '0;
`ifndef ARB_FIXED_PRIO_EN
          ptr <= (int'(last_id) == NREQ-1) ? '0 : last_id + 1'b1;
`endif
          if (HOLD_CYC > 0) begin
            state    <= HOLD;
            hold_cnt <= 4'(HOLD_CYC);
          end else begin
            state <= IDLE;
          end
        end
        HOLD: begin
          // Requests arriving here are deliberately dropped, not queued.
          gnt      <= '0;
          hold_cnt <= hold_cnt - 4'd1;
          if (hold_cnt == 4'd1) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
        end
      endcase
    end
  end

endmodule
